// File: rtl/simt_pkg.sv
// simt_pkg: shared types and encodings for the SIMT warp scheduler.
//   core_state_t   - scheduler core state encoding (exported on core_state)
//   FETCHED        - fetcher state value meaning the instruction is ready
//   LSU_*          - per-thread load/store unit states that hold the core in WAIT
package simt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } core_state_t;

  localparam logic [2:0] FETCHED        = 3'b010;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;

endpackage

// File: rtl/simt_min_pc.sv
// simt_min_pc: combinational minimum over the PCs of the valid threads.
//   pcs       in  packed per-thread PCs, thread i at [i*PC_BITS +: PC_BITS]
//   valid     in  per-thread participation mask
//   min_pc    out smallest PC among valid threads (0 when none valid)
//   any_valid out at least one thread is valid
module simt_min_pc #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned PC_BITS = 8
) (
  input  logic [PC_BITS*THREADS-1:0] pcs,
  input  logic [THREADS-1:0]         valid,
  output logic [PC_BITS-1:0]         min_pc,
  output logic                       any_valid
);

  always_comb begin
    min_pc    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < THREADS; i++) begin
      if (valid[i] && (!any_valid || pcs[i*PC_BITS +: PC_BITS] < min_pc)) begin
        min_pc    = pcs[i*PC_BITS +: PC_BITS];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simt_scheduler.sv
// simt_scheduler: per-block warp scheduler with SIMT divergence/reconvergence.
// Each thread keeps its own PC and finished flag; each instruction issues at
// the minimum PC of the unfinished threads and only threads at that PC execute.
//   clk, reset                 clock, async active-high reset
//   start                      launch block from IDLE
//   thread_count               valid threads (clamped to THREADS_PER_BLOCK)
//   fetcher_state              fetcher FSM state
//   decoded_mem_read_enable    instruction is a load
//   decoded_mem_write_enable   instruction is a store
//   decoded_ret                instruction is RET
//   lsu_state                  packed per-thread LSU states (2 bits each)
//   next_pc                    packed per-thread next PCs
//   core_state                 scheduler state
//   current_pc                 PC being issued
//   active_mask                threads executing the current instruction
//   diverged                   active_mask differs from unfinished mask
//   done                       all threads retired
module simt_scheduler
  import simt_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned PC_BITS           = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
  input  logic [2:0]                           fetcher_state,
  input  logic                                 decoded_mem_read_enable,
  input  logic                                 decoded_mem_write_enable,
  input  logic                                 decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                           core_state,
  output logic [PC_BITS-1:0]                   current_pc,
  output logic [THREADS_PER_BLOCK-1:0]         active_mask,
  output logic                                 diverged,
  output logic                                 done
);

  localparam int unsigned T    = THREADS_PER_BLOCK;
  localparam int unsigned TC_W = $clog2(THREADS_PER_BLOCK) + 1;

  core_state_t        state;
  logic [PC_BITS-1:0] thread_pc [T];
  logic [T-1:0]       finished;

  logic [TC_W-1:0]      tc_clamped;
  logic [T-1:0]         finished_init;
  logic [PC_BITS*T-1:0] upd_pc;
  logic [T-1:0]         upd_finished;
  logic                 lsu_busy;
  logic [PC_BITS-1:0]   min_pc;
  logic                 any_valid;

  assign core_state = state;

  always_comb begin
    tc_clamped = (thread_count > TC_W'(T)) ? TC_W'(T) : thread_count;
    finished_init = '0;
    for (int unsigned i = 0; i < T; i++) begin
      finished_init[i] = (i >= 32'(tc_clamped));
    end
  end

  always_comb begin
    active_mask = '0;
    for (int unsigned i = 0; i < T; i++) begin
      active_mask[i] = (state != ST_IDLE) && (state != ST_DONE) &&
                       !finished[i] && (thread_pc[i] == current_pc);
    end
  end

  assign diverged = (active_mask != ~finished);

  // Only active threads can stall the memory wait.
  always_comb begin
    lsu_busy = 1'b0;
    for (int unsigned i = 0; i < T; i++) begin
      if (active_mask[i] && (lsu_state[2*i +: 2] == LSU_REQUESTING ||
                             lsu_state[2*i +: 2] == LSU_WAITING)) begin
        lsu_busy = 1'b1;
      end
    end
  end

  // Post-UPDATE view of the thread state, so the next issue PC is chosen
  // from values that take effect on the same edge.
  always_comb begin
    upd_pc       = '0;
    upd_finished = finished;
    for (int unsigned i = 0; i < T; i++) begin
      upd_pc[i*PC_BITS +: PC_BITS] = thread_pc[i];
      if (active_mask[i]) begin
        if (decoded_ret) begin
          upd_finished[i] = 1'b1;
        end else begin
          upd_pc[i*PC_BITS +: PC_BITS] = next_pc[i*PC_BITS +: PC_BITS];
        end
      end
    end
  end

  simt_min_pc #(
    .THREADS (T),
    .PC_BITS (PC_BITS)
  ) u_min_pc (
    .pcs       (upd_pc),
    .valid     (~upd_finished),
    .min_pc    (min_pc),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      current_pc <= '0;
      done       <= 1'b0;
      finished   <= '1;
      for (int unsigned i = 0; i < T; i++) begin
        thread_pc[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < T; i++) begin
              thread_pc[i] <= '0;
            end
            current_pc <= '0;
            finished   <= finished_init;
            if (tc_clamped == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (fetcher_state == FETCHED) state <= ST_DECODE;
        end
        ST_DECODE:  state <= ST_REQUEST;
        ST_REQUEST: state <= ST_WAIT;
        ST_WAIT: begin
          if (!(decoded_mem_read_enable || decoded_mem_write_enable) || !lsu_busy) begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: state <= ST_UPDATE;
        ST_UPDATE: begin
          for (int unsigned i = 0; i < T; i++) begin
            thread_pc[i] <= upd_pc[i*PC_BITS +: PC_BITS];
          end
          finished <= upd_finished;
          if (any_valid) begin
            current_pc <= min_pc;
            state      <= ST_FETCH;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simt_scheduler.sv
// tb_simt_scheduler: directed self-checking bench for simt_scheduler
// (4 threads, 8-bit PCs). A small program table, selected per test, supplies
// next_pc / decoded_ret / load enable from the current issue PC.
module tb_simt_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  thread_count = '0;
  logic [2:0]  fetcher_state = 3'b010;
  logic        mem_rd;
  logic        mem_wr = 1'b0;
  logic        ret;
  logic [7:0]  lsu_state = 8'hFF;
  logic [31:0] next_pc;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic [3:0]  active_mask;
  logic        diverged;
  logic        done;

  int mode = 0;
  int checks = 0;
  int failures = 0;

  simt_scheduler #(
    .THREADS_PER_BLOCK (4),
    .PC_BITS           (8)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .thread_count             (thread_count),
    .fetcher_state            (fetcher_state),
    .decoded_mem_read_enable  (mem_rd),
    .decoded_mem_write_enable (mem_wr),
    .decoded_ret              (ret),
    .lsu_state                (lsu_state),
    .next_pc                  (next_pc),
    .core_state               (core_state),
    .current_pc               (current_pc),
    .active_mask              (active_mask),
    .diverged                 (diverged),
    .done                     (done)
  );

  always #5 clk = ~clk;

  // Program table: mode 0 uniform, 1 divergence, 2 memory, 3 partial RET.
  always_comb begin
    next_pc = '0;
    ret     = 1'b0;
    mem_rd  = 1'b0;
    for (int i = 0; i < 4; i++) next_pc[8*i +: 8] = current_pc + 8'd1;
    case (mode)
      1: begin
        if (current_pc == 8'd1) next_pc = {8'd5, 8'd2, 8'd2, 8'd5};
        ret = (current_pc == 8'd5);
      end
      2: begin
        if (current_pc == 8'd0) next_pc = {8'd9, 8'd1, 8'd1, 8'd1};
        ret    = (current_pc == 8'd2) || (current_pc == 8'd9);
        mem_rd = (current_pc == 8'd1);
      end
      3: begin
        if (current_pc == 8'd0) next_pc = {8'd6, 8'd6, 8'd3, 8'd3};
        ret = (current_pc == 8'd3) || (current_pc == 8'd6);
      end
      default: ret = (current_pc == 8'd2);
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check_issue(input string tag, input logic [7:0] pc,
                             input logic [3:0] mask, input logic div);
    check_val({tag, "_state"}, 32'(core_state), 32'd1);
    check_val({tag, "_pc"}, 32'(current_pc), 32'(pc));
    check_val({tag, "_mask"}, 32'(active_mask), 32'(mask));
    check_val({tag, "_div"}, 32'(diverged), 32'(div));
  endtask

  task automatic launch(input logic [2:0] tc);
    thread_count = tc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] div_pcs [6];
    logic [3:0] div_masks [6];
    logic       div_divs [6];
    logic [2:0] seq [5];
    div_pcs   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    div_masks = '{4'hF, 4'hF, 4'h6, 4'h6, 4'h6, 4'hF};
    div_divs  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    seq       = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

    // Reset state and zero-thread launch
    tick(1);
    check_val("rst_state", 32'(core_state), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_mask", 32'(active_mask), 32'd0);
    check_val("rst_pc", 32'(current_pc), 32'd0);
    check_val("rst_div", 32'(diverged), 32'd0);
    reset = 1'b0;
    tick(1);
    check_val("idle_hold", 32'(core_state), 32'd0);
    launch(3'd0);
    check_val("tc0_state", 32'(core_state), 32'd7);
    check_val("tc0_done", 32'(done), 32'd1);

    // Uniform flow with a stalled fetch on the first instruction
    do_reset();
    mode = 0;
    fetcher_state = 3'b001;
    launch(3'd3);
    check_issue("uni0", 8'd0, 4'b0111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val("fetch_stall", 32'(core_state), 32'd1);
    end
    fetcher_state = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_val("uni_seq", 32'(core_state), 32'(seq[i]));
      check_val("uni_seq_mask", 32'(active_mask), 32'd7);
    end
    tick(1);
    check_issue("uni1", 8'd1, 4'b0111, 1'b0);
    tick(6);
    check_issue("uni2", 8'd2, 4'b0111, 1'b0);
    tick(5);
    check_val("uni_pre_done", 32'(done), 32'd0);
    tick(1);
    check_val("uni_done_state", 32'(core_state), 32'd7);
    check_val("uni_done", 32'(done), 32'd1);
    check_val("uni_done_mask", 32'(active_mask), 32'd0);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    check_val("done_ignores_start", 32'(core_state), 32'd7);

    // Divergence and reconvergence; thread_count=5 clamps to 4
    do_reset();
    mode = 1;
    launch(3'd5);
    for (int k = 0; k < 6; k++) begin
      check_issue("div", div_pcs[k], div_masks[k], div_divs[k]);
      tick(6);
    end
    check_val("div_done", 32'(done), 32'd1);

    // Memory wait: active thread 1 WAITING, inactive thread 3 REQUESTING
    do_reset();
    mode = 2;
    lsu_state = 8'b01_11_10_11;
    launch(3'd4);
    check_issue("mem0", 8'd0, 4'hF, 1'b0);
    tick(6);
    check_issue("mem1", 8'd1, 4'b0111, 1'b1);
    tick(3);
    for (int i = 0; i < 7; i++) begin
      check_val("mem_wait_hold", 32'(core_state), 32'd4);
      tick(1);
    end
    lsu_state = 8'b01_11_11_11;
    check_val("mem_wait_last", 32'(core_state), 32'd4);
    tick(1);
    check_val("mem_exec", 32'(core_state), 32'd5);
    tick(2);
    check_issue("mem2", 8'd2, 4'b0111, 1'b1);
    tick(6);
    check_issue("mem9", 8'd9, 4'b1000, 1'b0);
    tick(6);
    check_val("mem_done", 32'(done), 32'd1);

    // Partial RET
    do_reset();
    mode = 3;
    lsu_state = 8'hFF;
    launch(3'd4);
    check_issue("pret0", 8'd0, 4'hF, 1'b0);
    tick(6);
    check_issue("pret3", 8'd3, 4'b0011, 1'b1);
    tick(6);
    check_issue("pret6", 8'd6, 4'b1100, 1'b0);
    check_val("pret6_done", 32'(done), 32'd0);
    tick(6);
    check_val("pret_done", 32'(done), 32'd1);

    // Async reset mid-WAIT, then restart
    do_reset();
    mode = 2;
    lsu_state = 8'b01_11_10_11;
    launch(3'd4);
    tick(9);
    tick(2);
    check_val("ar_in_wait", 32'(core_state), 32'd4);
    check_val("ar_pc_before", 32'(current_pc), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("ar_state", 32'(core_state), 32'd0);
    check_val("ar_pc", 32'(current_pc), 32'd0);
    check_val("ar_mask", 32'(active_mask), 32'd0);
    check_val("ar_div", 32'(diverged), 32'd0);
    check_val("ar_done", 32'(done), 32'd0);
    tick(1);
    reset = 1'b0;
    mode = 0;
    lsu_state = 8'hFF;
    launch(3'd4);
    check_issue("restart", 8'd0, 4'hF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
